// File: rtl/fm0_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : fm0_tx_encoder
// Description : Tag-side FM0 backscatter encoder. Emits an optional pilot
//               tone, a fixed preamble, handshaked data bits and a
//               terminating dummy-1 on tx_o at one of eight link rates.
// Revision    : 1.0 - initial release
// ============================================================================
module fm0_tx_encoder #(
  parameter int PILOT_BITS = 12,
  parameter int LEN_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [2:0]       set_rate_i,
  input  logic             trext_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             start_i,
  input  logic             data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  localparam int PC_W = $clog2(PILOT_BITS + 1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_PILOT    = 3'd1;
  localparam logic [2:0] c_ST_PREAMBLE = 3'd2;
  localparam logic [2:0] c_ST_DATA     = 3'd3;
  localparam logic [2:0] c_ST_DUMMY    = 3'd4;

  // Absolute half-bit levels, index 0 is transmitted first.
  localparam logic [0:11] c_PREAMBLE = 12'b1101_0010_0011;

  logic [2:0]       r_state;
  logic [7:0]       r_timer;
  logic [7:0]       r_reload;
  logic             r_trext;
  logic [LEN_W-1:0] r_len;
  logic             r_half;      // 0 = first half of the bit, 1 = second half
  logic [PC_W-1:0]  r_pilot_cnt;
  logic [3:0]       r_pre_idx;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [LEN_W:0]   r_fetched;
  logic             r_buf;
  logic             r_buf_full;
  logic             r_bit;       // data bit currently on the line
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_underrun;

  logic [7:0]       w_reload;
  logic             w_tick;
  logic             w_xfer;
  logic             w_bit_start;
  logic [3:0]       w_pre_next;
  logic             w_fetch_state;

  // Half-bit length minus one for the requested link rate.
  always_comb begin
    w_reload = 8'd194;
    case (set_rate_i)
      3'd0: w_reload = 8'd194;
      3'd1: w_reload = 8'd90;
      3'd2: w_reload = 8'd71;
      3'd3: w_reload = 8'd38;
      3'd4: w_reload = 8'd97;
      3'd5: w_reload = 8'd45;
      3'd6: w_reload = 8'd35;
      3'd7: w_reload = 8'd19;
      default: w_reload = 8'd194;
    endcase
  end

  assign w_tick        = (r_timer == 8'd0);
  assign w_pre_next    = r_pre_idx + 4'd1;
  assign w_fetch_state = (r_state == c_ST_PILOT) || (r_state == c_ST_PREAMBLE) ||
                         (r_state == c_ST_DATA);
  assign data_ready_o  = r_busy && !r_buf_full && (r_fetched < {1'b0, r_len}) &&
                         w_fetch_state;
  assign w_xfer        = data_valid_i && data_ready_o;

  // A new data bit begins either after the last preamble half or after a
  // completed data bit that is not the final one.
  assign w_bit_start = w_tick &&
    (((r_state == c_ST_PREAMBLE) && (r_pre_idx == 4'd11) && (r_len != '0)) ||
     ((r_state == c_ST_DATA) && r_half && (r_bit_cnt != r_len - LEN_W'(1))));

  // Frame sequencer: timer, state, line level, buffer and status pulses.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_timer     <= 8'd0;
      r_reload    <= 8'd0;
      r_trext     <= 1'b0;
      r_len       <= '0;
      r_half      <= 1'b0;
      r_pilot_cnt <= '0;
      r_pre_idx   <= 4'd0;
      r_bit_cnt   <= '0;
      r_fetched   <= '0;
      r_buf       <= 1'b0;
      r_buf_full  <= 1'b0;
      r_bit       <= 1'b0;
      r_tx        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;

      if (w_xfer) begin
        r_buf      <= data_i;
        r_buf_full <= 1'b1;
        r_fetched  <= r_fetched + 1'b1;
      end

      if (r_state == c_ST_IDLE) begin
        if (start_i) begin
          r_reload    <= w_reload;
          r_timer     <= w_reload;
          r_trext     <= trext_i;
          r_len       <= len_i;
          r_half      <= 1'b0;
          r_pilot_cnt <= '0;
          r_pre_idx   <= 4'd0;
          r_bit_cnt   <= '0;
          r_fetched   <= '0;
          r_buf_full  <= 1'b0;
          r_busy      <= 1'b1;
          r_tx        <= 1'b1;   // both pilot and preamble open at level 1
          r_state     <= trext_i ? c_ST_PILOT : c_ST_PREAMBLE;
        end
      end else begin
        r_timer <= w_tick ? r_reload : r_timer - 8'd1;
        if (w_tick) begin
          case (r_state)
            c_ST_PILOT: begin
              if (!r_half) begin
                r_half <= 1'b1;
                r_tx   <= ~r_tx;
              end else if (r_pilot_cnt == PC_W'(PILOT_BITS - 1)) begin
                r_state   <= c_ST_PREAMBLE;
                r_pre_idx <= 4'd0;
                r_tx      <= c_PREAMBLE[0];
              end else begin
                r_pilot_cnt <= r_pilot_cnt + 1'b1;
                r_half      <= 1'b0;
                r_tx        <= ~r_tx;
              end
            end
            c_ST_PREAMBLE: begin
              if (r_pre_idx != 4'd11) begin
                r_pre_idx <= w_pre_next;
                r_tx      <= c_PREAMBLE[w_pre_next];
              end else if (r_len == '0) begin
                r_state <= c_ST_DUMMY;
                r_half  <= 1'b0;
                r_tx    <= ~r_tx;
              end
            end
            c_ST_DATA: begin
              if (!r_half) begin
                r_half <= 1'b1;
                if (!r_bit) r_tx <= ~r_tx;
              end else if (r_bit_cnt == r_len - LEN_W'(1)) begin
                r_state <= c_ST_DUMMY;
                r_half  <= 1'b0;
                r_tx    <= ~r_tx;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            c_ST_DUMMY: begin
              if (!r_half) begin
                r_half <= 1'b1;
              end else begin
                r_state <= c_ST_IDLE;
                r_tx    <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
            default: r_state <= c_ST_IDLE;
          endcase
        end

        // Data bit boundary: consume the buffered bit or abort on underrun.
        if (w_bit_start) begin
          if (r_buf_full) begin
            r_state    <= c_ST_DATA;
            r_half     <= 1'b0;
            r_tx       <= ~r_tx;
            r_bit      <= r_buf;
            r_buf_full <= 1'b0;
          end else begin
            r_state    <= c_ST_IDLE;
            r_tx       <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b1;
          end
        end
      end
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign underrun_o = r_underrun;

endmodule
`default_nettype wire
